// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the exception controller: exception type codes,
// CP0 Status/Cause bit positions, stall vectors and the drain FSM state type.
package exception_ctrl_pkg;

   localparam int unsigned EXC_TYPE_W = 32;

   localparam logic [EXC_TYPE_W-1:0] ExcNone         = 32'h0000_0000;
   localparam logic [EXC_TYPE_W-1:0] Exc_Interrupt   = 32'h0000_0001;
   localparam logic [EXC_TYPE_W-1:0] Exc_Syscall     = 32'h0000_0008;
   localparam logic [EXC_TYPE_W-1:0] Exc_InvalidInst = 32'h0000_0009;
   localparam logic [EXC_TYPE_W-1:0] Exc_Trap        = 32'h0000_000d;
   localparam logic [EXC_TYPE_W-1:0] Exc_Overflow    = 32'h0000_000c;
   localparam logic [EXC_TYPE_W-1:0] Exc_Eret        = 32'h0000_000e;

   localparam int unsigned STATUS_IE    = 0;
   localparam int unsigned STATUS_EXL   = 1;
   localparam int unsigned STATUS_IM_LO = 8;
   localparam int unsigned STATUS_IM_HI = 15;
   localparam int unsigned CAUSE_IP_LO  = 8;
   localparam int unsigned CAUSE_IP_HI  = 15;

   // Bit positions inside mem_exc_flags_i = {eret, overflow, trap, invalid_inst, syscall}
   localparam int unsigned FLAG_SYSCALL  = 0;
   localparam int unsigned FLAG_INVALID  = 1;
   localparam int unsigned FLAG_TRAP     = 2;
   localparam int unsigned FLAG_OVERFLOW = 3;
   localparam int unsigned FLAG_ERET     = 4;

   // Stall vector order is {wb, mem, ex, id, if, pc}
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;

   localparam int unsigned DRAIN_W = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

endpackage

// File: rtl/exception_ctrl_priority_enc.sv
// Fixed-priority fold of the pending interrupt and MEM-stage exception flags
// into a single exception type code.
module exc_priority_enc
   import exception_ctrl_pkg::*;
(
   input  logic                  int_pend,
   input  logic [4:0]            flags,
   output logic [EXC_TYPE_W-1:0] exc_type
);

   always_comb begin
      exc_type = ExcNone;
      if (int_pend)
         exc_type = Exc_Interrupt;
      else if (flags[FLAG_SYSCALL])
         exc_type = Exc_Syscall;
      else if (flags[FLAG_INVALID])
         exc_type = Exc_InvalidInst;
      else if (flags[FLAG_TRAP])
         exc_type = Exc_Trap;
      else if (flags[FLAG_OVERFLOW])
         exc_type = Exc_Overflow;
      else if (flags[FLAG_ERET])
         exc_type = Exc_Eret;
   end

endmodule

// File: rtl/exception_ctrl.sv
// Exception arbiter and pipeline controller: produces the exception type for CP0,
// flush/redirect and stall vector, and masks exceptions while a flushed pipeline drains.
module exception_ctrl
   import exception_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_valid_i,
   input  logic [31:0]           mem_inst_addr_i,
   input  logic [4:0]            mem_exc_flags_i,
   input  logic [31:0]           cp0_status_i,
   input  logic [31:0]           cp0_cause_i,
   input  logic [31:0]           cp0_epc_i,
   input  logic                  stallreq_id_i,
   input  logic                  stallreq_ex_i,
   output logic [EXC_TYPE_W-1:0] exception_type_o,
   output logic                  flush_o,
   output logic [31:0]           new_pc_o,
   output logic [5:0]            stall_o,
   output logic [CNT_W-1:0]      exc_count_o,
   output logic                  busy_o
);

   state_t                  state;
   logic [DRAIN_W-1:0]      drain_cnt;
   logic                    int_pend;
   logic                    arb_en;
   logic [EXC_TYPE_W-1:0]   enc_type;
   logic                    unused_inputs;

   // The instruction PC is latched into EPC by CP0 itself; only the IM/IP/IE/EXL fields matter here.
   assign unused_inputs = &{1'b0, mem_inst_addr_i, cp0_status_i[31:16], cp0_status_i[7:2],
                            cp0_cause_i[31:16], cp0_cause_i[7:0]};

   assign int_pend = (|(cp0_cause_i[CAUSE_IP_HI:CAUSE_IP_LO] & cp0_status_i[STATUS_IM_HI:STATUS_IM_LO]))
                     & cp0_status_i[STATUS_IE] & ~cp0_status_i[STATUS_EXL];

   exc_priority_enc u_enc (
      .int_pend (int_pend),
      .flags    (mem_exc_flags_i),
      .exc_type (enc_type)
   );

   assign arb_en = rst & (state == ST_IDLE) & mem_valid_i;
   assign busy_o = (state == ST_DRAIN);

   always_comb begin
      exception_type_o = ExcNone;
      flush_o          = 1'b0;
      new_pc_o         = '0;
      stall_o          = STALL_NONE;
      if (rst) begin
         if (arb_en)
            exception_type_o = enc_type;
         if (exception_type_o != ExcNone) begin
            flush_o  = 1'b1;
            new_pc_o = (exception_type_o == Exc_Eret) ? cp0_epc_i : EXC_VECTOR;
         end else if (stallreq_ex_i) begin
            stall_o = STALL_EX;
         end else if (stallreq_id_i) begin
            stall_o = STALL_ID;
         end
      end
   end

   // DRAIN_CYCLES is expected in 1..15; the counter leaves DRAIN when it reads 1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         drain_cnt   <= '0;
         exc_count_o <= '0;
      end else begin
         if (flush_o && (exc_count_o != '1))
            exc_count_o <= exc_count_o + CNT_W'(1);
         case (state)
            ST_IDLE: begin
               if (flush_o) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == DRAIN_W'(1)) begin
                  state     <= ST_IDLE;
                  drain_cnt <= '0;
               end else begin
                  drain_cnt <= drain_cnt - DRAIN_W'(1);
               end
            end
            default: begin
               state     <= ST_IDLE;
               drain_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios plus randomized
// cycles compared against a priority-table reference model.
module tb_exception_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic [31:0] mem_pc;
   logic [4:0]  flags;
   logic [31:0] status, cause, epc;
   logic        sreq_id, sreq_ex;

   logic [31:0] exception_type_o, new_pc_o;
   logic        flush_o, busy_o;
   logic [5:0]  stall_o;
   logic [15:0] exc_count_o;

   logic [31:0] type2, npc2;
   logic        flush2, busy2;
   logic [5:0]  stall2;
   logic [1:0]  cnt2;

   int checks = 0;
   int failures = 0;
   int m_mask = 0;
   int m_taken = 0;

   // Codes for {syscall, invalid_inst, trap, overflow, eret}, indexed by flag bit, highest priority first
   logic [31:0] flag_code [5] = '{32'h8, 32'h9, 32'hd, 32'hc, 32'he};

   exception_ctrl #(.EXC_VECTOR(32'h0000_0020), .DRAIN_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .mem_inst_addr_i(mem_pc),
      .mem_exc_flags_i(flags), .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
      .stallreq_id_i(sreq_id), .stallreq_ex_i(sreq_ex), .exception_type_o(exception_type_o),
      .flush_o(flush_o), .new_pc_o(new_pc_o), .stall_o(stall_o), .exc_count_o(exc_count_o),
      .busy_o(busy_o));

   exception_ctrl #(.EXC_VECTOR(32'h0000_0020), .DRAIN_CYCLES(2), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .mem_inst_addr_i(mem_pc),
      .mem_exc_flags_i(flags), .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
      .stallreq_id_i(sreq_id), .stallreq_ex_i(sreq_ex), .exception_type_o(type2),
      .flush_o(flush2), .new_pc_o(npc2), .stall_o(stall2), .exc_count_o(cnt2),
      .busy_o(busy2));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

   function automatic logic [31:0] ref_type(input logic valid, input int mask,
                                            input logic [31:0] st, input logic [31:0] cs,
                                            input logic [4:0] fl);
      logic ip;
      ip = (|(cs[15:8] & st[15:8])) && st[0] && !st[1];
      if (!valid || mask > 0) return 32'h0;
      if (ip) return 32'h1;
      for (int i = 0; i < 5; i++)
         if (fl[i]) return flag_code[i];
      return 32'h0;
   endfunction

   function automatic int sat(input int n, input int lim);
      return (n > lim) ? lim : n;
   endfunction

   // Commit the current cycle to the model, then move to 1 time unit past the next edge.
   task automatic advance();
      logic [31:0] t;
      t = ref_type(mem_valid, m_mask, status, cause, flags);
      if (!rst) begin
         m_mask = 0;
         m_taken = 0;
      end else if (t != 32'h0) begin
         m_mask = 2;
         m_taken++;
      end else if (m_mask > 0) begin
         m_mask--;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain_out();
      mem_valid = 1'b0;
      for (int i = 0; i < 10 && m_mask > 0; i++) advance();
   endtask

   task automatic test_reset();
      rst = 1'b0; mem_valid = 1'b1; flags = 5'b00001; sreq_ex = 1'b1;
      status = 32'h0000_ff01; cause = 32'h0000_0400; epc = 32'h0; mem_pc = 32'h0; sreq_id = 1'b1;
      @(posedge clk); #1;
      checks++; if (exception_type_o !== 32'h0) begin failures++; $display("FAIL rst_type got=%h exp=%h", exception_type_o, 32'h0); end
      checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b exp=0", flush_o); end
      checks++; if (new_pc_o !== 32'h0) begin failures++; $display("FAIL rst_newpc got=%h exp=0", new_pc_o); end
      checks++; if (stall_o !== 6'b0) begin failures++; $display("FAIL rst_stall got=%b exp=000000", stall_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
      checks++; if (exc_count_o !== 16'h0) begin failures++; $display("FAIL rst_count got=%h exp=0", exc_count_o); end
      mem_valid = 1'b0; flags = '0; sreq_ex = 1'b0; sreq_id = 1'b0;
      m_mask = 0; m_taken = 0;
      #2 rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_interrupt();
      status = 32'h0000_ff01; cause = 32'h0000_0400; mem_valid = 1'b1; mem_pc = 32'h100; flags = '0;
      #1;
      checks++; if (exception_type_o !== 32'h1) begin failures++; $display("FAIL int_type got=%h exp=1", exception_type_o); end
      checks++; if (flush_o !== 1'b1) begin failures++; $display("FAIL int_flush got=%b exp=1", flush_o); end
      checks++; if (new_pc_o !== 32'h20) begin failures++; $display("FAIL int_newpc got=%h exp=20", new_pc_o); end
      checks++; if (stall_o !== 6'b0) begin failures++; $display("FAIL int_stall got=%b exp=000000", stall_o); end
      advance();
      mem_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL int_busy%0d got=%b exp=1", i, busy_o); end
         advance();
      end
      #1;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL int_idle got=%b exp=0", busy_o); end
      checks++; if (exc_count_o !== 16'(m_taken)) begin failures++; $display("FAIL int_count got=%0d exp=%0d", exc_count_o, m_taken); end
   endtask

   task automatic test_valid_gating();
      status = 32'h0000_ff01; cause = 32'h0000_0400; mem_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (exception_type_o !== 32'h0) begin failures++; $display("FAIL gate_type%0d got=%h exp=0", i, exception_type_o); end
         checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL gate_flush%0d got=%b exp=0", i, flush_o); end
         advance();
      end
      mem_valid = 1'b1;
      #1;
      checks++; if (exception_type_o !== 32'h1) begin failures++; $display("FAIL gate_taken got=%h exp=1", exception_type_o); end
      advance();
      drain_out();
   endtask

   task automatic test_sync_exl();
      status = 32'h0000_ff03; cause = 32'h0000_0400; flags = 5'b01001; mem_valid = 1'b1;
      #1;
      checks++; if (exception_type_o !== 32'h8) begin failures++; $display("FAIL exl_type got=%h exp=8", exception_type_o); end
      checks++; if (new_pc_o !== 32'h20) begin failures++; $display("FAIL exl_newpc got=%h exp=20", new_pc_o); end
      advance();
      checks++; if (exc_count_o !== 16'(m_taken)) begin failures++; $display("FAIL exl_count got=%0d exp=%0d", exc_count_o, m_taken); end
      flags = '0;
      drain_out();
   endtask

   task automatic test_eret();
      status = 32'h0000_0002; cause = 32'h0; flags = 5'b10000; epc = 32'h0000_0abc; mem_valid = 1'b1;
      #1;
      checks++; if (exception_type_o !== 32'he) begin failures++; $display("FAIL eret_type got=%h exp=e", exception_type_o); end
      checks++; if (new_pc_o !== 32'h0abc) begin failures++; $display("FAIL eret_newpc got=%h exp=abc", new_pc_o); end
      checks++; if (flush_o !== 1'b1) begin failures++; $display("FAIL eret_flush got=%b exp=1", flush_o); end
      advance();
      flags = '0;
      drain_out();
   endtask

   task automatic test_drain_stall();
      status = 32'h0; cause = 32'h0; flags = 5'b00100; mem_valid = 1'b1; sreq_ex = 1'b0; sreq_id = 1'b0;
      #1;
      checks++; if (exception_type_o !== 32'hd) begin failures++; $display("FAIL trap_type got=%h exp=d", exception_type_o); end
      advance();
      sreq_ex = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL drain_flush%0d got=%b exp=0", i, flush_o); end
         checks++; if (exception_type_o !== 32'h0) begin failures++; $display("FAIL drain_type%0d got=%h exp=0", i, exception_type_o); end
         checks++; if (stall_o !== 6'b001111) begin failures++; $display("FAIL drain_stall%0d got=%b exp=001111", i, stall_o); end
         advance();
      end
      #1;
      checks++; if (exception_type_o !== 32'hd) begin failures++; $display("FAIL trap_retake got=%h exp=d", exception_type_o); end
      checks++; if (stall_o !== 6'b0) begin failures++; $display("FAIL flush_over_stall got=%b exp=000000", stall_o); end
      advance();
      sreq_ex = 1'b0; sreq_id = 1'b1;
      #1;
      checks++; if (stall_o !== 6'b000111) begin failures++; $display("FAIL drain_idstall got=%b exp=000111", stall_o); end
      advance();
      sreq_id = 1'b0; flags = '0;
      drain_out();
   endtask

   task automatic test_reset_mid_drain();
      status = 32'h0; cause = 32'h0; flags = 5'b00001; mem_valid = 1'b1;
      #1;
      advance();
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy_o); end
      sreq_ex = 1'b1;
      #2 rst = 1'b0;
      #1;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_drain_busy got=%b exp=0", busy_o); end
      checks++; if (stall_o !== 6'b0) begin failures++; $display("FAIL rst_drain_stall got=%b exp=000000", stall_o); end
      flags = 5'b00010; sreq_ex = 1'b0;
      m_mask = 0; m_taken = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++; if (exception_type_o !== 32'h9) begin failures++; $display("FAIL post_rst_type got=%h exp=9", exception_type_o); end
      checks++; if (exc_count_o !== 16'h0) begin failures++; $display("FAIL post_rst_count got=%0d exp=0", exc_count_o); end
      advance();
      flags = '0;
      drain_out();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 5; i++) begin
         status = 32'h0; flags = 5'b00001; mem_valid = 1'b1;
         #1;
         checks++; if (cnt2 !== 2'(sat(m_taken, 3))) begin failures++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, cnt2, sat(m_taken, 3)); end
         advance();
         drain_out();
      end
      checks++; if (cnt2 !== 2'd3) begin failures++; $display("FAIL sat_hold got=%0d exp=3", cnt2); end
      checks++; if (exc_count_o !== 16'(m_taken)) begin failures++; $display("FAIL sat_wide got=%0d exp=%0d", exc_count_o, m_taken); end
   endtask

   task automatic test_random();
      logic [31:0] t, e_pc;
      logic        e_fl;
      logic [5:0]  e_st;
      logic [87:0] got, exp;
      logic [73:0] got2, exp2;
      for (int n = 0; n < 400; n++) begin
         mem_valid = ($urandom_range(0, 3) != 0);
         mem_pc = $urandom;
         flags = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
         status = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
         cause = {16'h0, 8'($urandom), 8'h0};
         epc = $urandom;
         sreq_id = 1'($urandom);
         sreq_ex = ($urandom_range(0, 3) == 0);
         #1;
         t = ref_type(mem_valid, m_mask, status, cause, flags);
         e_fl = (t != 32'h0);
         e_pc = !e_fl ? 32'h0 : ((t == 32'he) ? epc : 32'h20);
         e_st = e_fl ? 6'b0 : (sreq_ex ? 6'b001111 : (sreq_id ? 6'b000111 : 6'b0));
         got = {exception_type_o, flush_o, new_pc_o, stall_o, busy_o, exc_count_o};
         exp = {t, e_fl, e_pc, e_st, (m_mask > 0), 16'(m_taken)};
         checks++; if (got !== exp) begin failures++; $display("FAIL rand%0d got=%h exp=%h", n, got, exp); end
         got2 = {type2, flush2, npc2, stall2, busy2, cnt2};
         exp2 = {t, e_fl, e_pc, e_st, (m_mask > 0), 2'(sat(m_taken, 3))};
         checks++; if (got2 !== exp2) begin failures++; $display("FAIL rand2_%0d got=%h exp=%h", n, got2, exp2); end
         advance();
      end
   endtask

   initial begin
      rst = 1'b0;
      mem_valid = 1'b0; mem_pc = '0; flags = '0; status = '0; cause = '0; epc = '0;
      sreq_id = 1'b0; sreq_ex = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_interrupt();
      test_valid_gating();
      test_sync_exl();
      test_eret();
      test_drain_stall();
      test_reset_mid_drain();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
